dmem_access_ctrl: RTL and testbench

Multi-cycle load/store controller between the core's memory stage and the word-only data memory. Accepts one RV32I load or store per handshake and checks natural alignment. Performs read-modify-write for `sb`/`sh`, because data memory writes whole words only. Returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/dmem_access_ctrl_pkg.sv | 42 ++++
 rtl/dmem_access_ctrl_lane.sv | 63 ++++++
 rtl/dmem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg
// Shared definitions for the data-memory load/store controller:
//   - RV32I load/store funct3 codes (size and signedness)
//   - controller state encoding (3 bits)
//   - ls_illegal(): alignment / encoding legality check for one request
package dmem_access_ctrl_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [2:0] {
        DAC_IDLE = 3'd0,
        DAC_RD   = 3'd1,
        DAC_WR   = 3'd2,
        DAC_RESP = 3'd3,
        DAC_ERR  = 3'd4
    } dac_state_e;

    // A request is illegal if funct3 is unused, if a store asks for an
    // unsigned size (bit 2 only means "zero-extend" for loads), or if the
    // address is not naturally aligned for the access size.
    function automatic logic ls_illegal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            LS_B, LS_BU: bad = 1'b0;
            LS_H, LS_HU: bad = lo[0];
            LS_W:        bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (is_store && f3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane.sv
// ls_lane
// Purely combinational byte/half lane logic for a word-only memory.
// Ports:
//   word       in  XLEN : memory word being read or modified
//   addr_lo    in  2    : low address bits (byte lane / half lane select)
//   funct3     in  3    : RV32I size/sign field
//   wdata      in  XLEN : right-justified store data
//   load_data  out XLEN : extracted and sign/zero-extended load value
//   store_word out XLEN : word with the store data merged into its lane
module ls_lane
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: byte lane is addr[1:0], half lane is addr[1].
    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Load extension: signed sizes replicate the lane's top bit.
    always_comb begin
        load_data = '0;
        case (funct3)
            LS_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LS_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
            LS_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LS_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
            LS_W:    load_data = word;
            default: load_data = '0;
        endcase
    end

    // Store merge: sub-word stores overwrite only their lane of the
    // previously read word, so the memory can take a full-word write.
    always_comb begin
        store_word = word;
        case (funct3)
            LS_B:    store_word[8*addr_lo +: 8] = wdata[7:0];
            LS_H:    begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            LS_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Multi-cycle RV32I load/store controller in front of a word-only data
// memory. One request per handshake; sub-word stores are done as
// read-modify-write. Completion is a one-cycle resp_valid pulse.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_we, req_funct3    : store flag and RV32I size/sign field
//   req_addr, req_wdata   : byte address and right-justified store data
//   req_pc                : instruction PC, forwarded as mem_pc
//   resp_valid/err/rdata  : completion pulse, error flag, load result
//   mem_we/a/wd/pc        : word write strobe, aligned address, data, PC
//   mem_rd                : combinational read data for mem_a
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [ADDR_SIZE-1:0] req_pc,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_a,
    output logic [XLEN-1:0]      mem_wd,
    output logic [ADDR_SIZE-1:0] mem_pc,
    input  logic [XLEN-1:0]      mem_rd
);

    dac_state_e state_q, state_d;

    logic [XLEN-1:0]      addr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [2:0]           funct3_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] pc_q;
    logic [XLEN-1:0]      word_q;
    logic [XLEN-1:0]      rdata_q;

    logic                 accept;
    logic [XLEN-1:0]      lane_word;
    logic [XLEN-1:0]      lane_load;
    logic [XLEN-1:0]      lane_store;

    assign accept = req_valid && (state_q == DAC_IDLE);

    // In RD the load result is taken straight from mem_rd so it can be
    // registered on the RD->RESP edge; in WR the merge uses the word
    // captured during RD.
    assign lane_word = (state_q == DAC_RD) ? mem_rd : word_q;

    ls_lane #(.XLEN(XLEN)) u_lane (
        .word       (lane_word),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    // State register plus request latches. rdata_q is cleared on accept so
    // stores and errors respond with zero, and otherwise holds the last
    // load result until the next request is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DAC_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            pc_q     <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                we_q     <= req_we;
                pc_q     <= req_pc;
                rdata_q  <= '0;
            end
            if (state_q == DAC_RD) begin
                word_q <= mem_rd;
                if (!we_q) begin
                    rdata_q <= lane_load;
                end
            end
        end
    end

    // Next-state logic. Only full-word stores skip the read phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DAC_IDLE: begin
                if (req_valid) begin
                    if (ls_illegal(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = DAC_ERR;
                    end else if (!req_we || (req_funct3 != LS_W)) begin
                        state_d = DAC_RD;
                    end else begin
                        state_d = DAC_WR;
                    end
                end
            end
            DAC_RD:   state_d = we_q ? DAC_WR : DAC_RESP;
            DAC_WR:   state_d = DAC_RESP;
            DAC_RESP: state_d = DAC_IDLE;
            DAC_ERR:  state_d = DAC_IDLE;
            default:  state_d = DAC_IDLE;
        endcase
    end

    // Outputs. The write strobe is gated by reset so a reset landing on a
    // WR cycle never reaches memory.
    always_comb begin
        req_ready  = (state_q == DAC_IDLE);
        resp_valid = (state_q == DAC_RESP) || (state_q == DAC_ERR);
        resp_err   = (state_q == DAC_ERR);
        resp_rdata = rdata_q;
        mem_we     = (state_q == DAC_WR) && !reset;
        mem_wd     = '0;
        mem_a      = '0;
        mem_pc     = '0;
        if (state_q == DAC_WR) begin
            mem_wd = lane_store;
        end
        if (state_q != DAC_IDLE) begin
            mem_a  = {addr_q[XLEN-1:2], 2'b00};
            mem_pc = pc_q;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
// Directed bench for dmem_access_ctrl with a word RAM attached to the
// memory port, a transaction-level reference model and a per-cycle
// compare process.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_pc;
    logic [31:0] mem_rd;

    logic [31:0] ram       [0:1023];
    logic [31:0] model_mem [0:1023];

    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    int checks;
    int errors;
    int cyc;

    // Expected transaction, written only by the stimulus process
    bit          pending;
    int          base;
    int          resp_at;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          exp_dowr;
    logic [31:0] exp_wword;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;

    // Observations, written only by the compare process
    int          resp_count;
    int          we_count;
    int          last_resp_cyc;
    logic [31:0] last_rdata;
    logic        last_err;

    dmem_access_ctrl #(.XLEN(32), .ADDR_SIZE(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_pc     (mem_pc),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word RAM seen by the controller, with a preload port for setup
    assign mem_rd = ram[mem_a[11:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_a[11:2]] <= mem_wd;
        end else if (pl_en) begin
            ram[pl_idx] <= pl_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a single request must do, from the ISA rules
    task automatic modelTxn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output bit err, output int lat,
                            output logic [31:0] rdata, output bit dowr, output logic [31:0] wword);
        logic [7:0]  b [4];
        logic [31:0] w;
        logic [15:0] h;
        int          a;
        w = model_mem[addr[11:2]];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        a = int'(addr[1:0]);
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
              ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && a != 0);
        rdata = 32'h0;
        dowr  = 1'b0;
        wword = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            h = (a < 3) ? {b[a+1], b[a]} : 16'h0;
            case (f3)
                3'd0: rdata = {{24{b[a][7]}}, b[a]};
                3'd4: rdata = {24'h0, b[a]};
                3'd1: rdata = {{16{h[15]}}, h};
                3'd5: rdata = {16'h0, h};
                default: rdata = w;
            endcase
        end else begin
            dowr = 1'b1;
            if (f3 == 3'd2) begin
                lat = 2;
                wword = wdata;
            end else begin
                lat = 3;
                if (f3 == 3'd0) begin
                    b[a] = wdata[7:0];
                end else begin
                    b[a]   = wdata[7:0];
                    b[a+1] = wdata[15:8];
                end
                wword = {b[3], b[2], b[1], b[0]};
            end
        end
    endtask

    // Compare process: every cycle after the first edge
    always @(negedge clk) begin
        bit in_txn;
        bit ev;
        bit ew;
        if (cyc >= 1) begin
            in_txn = pending && (cyc >= base) && (cyc <= resp_at);
            ev     = in_txn && (cyc == resp_at);
            ew     = in_txn && exp_dowr && (cyc == resp_at - 1) && !reset;
            checkOutput("req_ready", {31'h0, req_ready}, {31'h0, in_txn ? 1'b0 : 1'b1});
            checkOutput("resp_valid", {31'h0, resp_valid}, {31'h0, ev});
            checkOutput("mem_we", {31'h0, mem_we}, {31'h0, ew});
            checkOutput("mem_a", mem_a, in_txn ? exp_addr : 32'h0);
            checkOutput("mem_pc", mem_pc, in_txn ? exp_pc : 32'h0);
            if (ev) begin
                checkOutput("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
                checkOutput("resp_rdata", resp_rdata, exp_rdata);
            end
            if (ew) begin
                checkOutput("mem_wd", mem_wd, exp_wword);
            end
            if (resp_valid) begin
                resp_count++;
                last_resp_cyc = cyc;
                last_rdata    = resp_rdata;
                last_err      = resp_err;
            end
            if (mem_we) we_count++;
        end
    end

    // Drive one request, wait out its expected latency and commit the model
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pc, output int lat);
        bit          err;
        logic [31:0] rdata;
        bit          dowr;
        logic [31:0] wword;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_pc     = pc;
        modelTxn(we, f3, addr, wdata, err, lat, rdata, dowr, wword);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_err   = err;
        exp_rdata = rdata;
        exp_dowr  = dowr;
        exp_wword = wword;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_pc    = pc;
        base      = cyc;
        resp_at   = cyc + lat - 1;
        pending   = 1'b1;
        repeat (lat) @(posedge clk);
        #1;
        if (dowr) model_mem[addr[11:2]] = wword;
    endtask

    // One request with literal expectations on result, latency and writes
    task automatic directed(input string name, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_lit, input int lat_lit, input int we_lit);
        int lat;
        int r0;
        int w0;
        r0 = resp_count;
        w0 = we_count;
        applyStimulus(we, f3, addr, wdata, 32'h1000 + addr, lat);
        checkOutput({name, "_resp_count"}, 32'(resp_count - r0), 32'd1);
        checkOutput({name, "_latency"}, 32'(last_resp_cyc - base + 1), 32'(lat_lit));
        checkOutput({name, "_rdata"}, last_rdata, exp_lit);
        checkOutput({name, "_we_pulses"}, 32'(we_count - w0), 32'(we_lit));
    endtask

    initial begin
        int r0;
        int w0;
        checks = 0; errors = 0; cyc = 0;
        pending = 1'b0; base = 0; resp_at = 0;
        exp_err = 0; exp_rdata = 0; exp_dowr = 0; exp_wword = 0; exp_addr = 0; exp_pc = 0;
        resp_count = 0; we_count = 0; last_resp_cyc = 0; last_rdata = 0; last_err = 0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_pc = 0;
        pl_en = 1'b1; pl_idx = 10'd4; pl_data = 32'h8C7B6A59;
        model_mem[4] = 32'h8C7B6A59;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pl_en = 1'b0;
        checkOutput("rst_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'h0, resp_err}, 32'd0);
        checkOutput("rst_rdata", resp_rdata, 32'h0);
        checkOutput("rst_mem_we", {31'h0, mem_we}, 32'd0);
        checkOutput("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        directed("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF8C, 2, 0);
        directed("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008C7B, 2, 0);
        directed("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8C7B6A59, 2, 0);
        directed("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8C7B, 2, 0);
        directed("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000006A, 2, 0);
        directed("sb11",  1'b1, 3'b000, 32'h11, 32'hEE, 32'h0, 3, 1);
        checkOutput("sb11_ram", ram[4], 32'h8C7BEE59);
        directed("sw20",  1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 2, 1);
        directed("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 2, 0);
        directed("sh21",  1'b1, 3'b001, 32'h21, 32'hABCD, 32'h0, 1, 0);
        checkOutput("sh21_err", {31'h0, last_err}, 32'd1);
        directed("lw22",  1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 0);
        checkOutput("lw22_err", {31'h0, last_err}, 32'd1);
        directed("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0);
        checkOutput("f3_011_err", {31'h0, last_err}, 32'd1);
        directed("sbu",   1'b1, 3'b100, 32'h10, 32'h11, 32'h0, 1, 0);
        directed("sh22",  1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 3, 1);
        checkOutput("sh22_ram", ram[8], 32'hBEEF5678);
        directed("lb23",  1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFBE, 2, 0);

        // Reset landing on the WR cycle of a byte store
        r0 = resp_count;
        w0 = we_count;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h12; req_wdata = 32'h55; req_pc = 32'h2000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_err = 0; exp_rdata = 0; exp_dowr = 1; exp_wword = 32'h8C55EE59;
        exp_addr = 32'h10; exp_pc = 32'h2000;
        base = cyc; resp_at = cyc + 2; pending = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pending = 1'b0;
        checkOutput("rstwr_ready", {31'h0, req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstwr_no_resp", 32'(resp_count - r0), 32'd0);
        checkOutput("rstwr_no_we", 32'(we_count - w0), 32'd0);
        checkOutput("rstwr_ram", ram[4], 32'h8C7BEE59);
        directed("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8C7BEE59, 2, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
